// File: rtl/reservation_station.sv
// Tomasulo reservation station with a private add/sub or multiply unit.
// Entries snoop the CDB; one entry at a time executes and writes back via request/grant.

module rs_entry #(
    parameter int DATA_W = 9,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_alloc,
    input  logic              i_op,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [DATA_W-1:0] i_vk,
    input  logic [TAG_W-1:0]  i_qj,
    input  logic [TAG_W-1:0]  i_qk,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_dispatch,
    input  logic              i_free,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_op,
    output logic [DATA_W-1:0] o_vj,
    output logic [DATA_W-1:0] o_vk
);
    typedef struct packed {
        logic              busy;
        logic              op;
        logic              disp;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } ent_t;

    ent_t r_e;
    logic w_hit_j, w_hit_k;

    // Tag 0 means "no producer", so a tag-0 broadcast must never match.
    assign w_hit_j = r_e.busy && i_cdb_valid && (i_cdb_tag != '0) && (r_e.qj == i_cdb_tag);
    assign w_hit_k = r_e.busy && i_cdb_valid && (i_cdb_tag != '0) && (r_e.qk == i_cdb_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_e <= '0;
        end else if (i_alloc) begin
            r_e.busy <= 1'b1;
            r_e.op   <= i_op;
            r_e.disp <= 1'b0;
            r_e.vj   <= i_vj;
            r_e.vk   <= i_vk;
            r_e.qj   <= i_qj;
            r_e.qk   <= i_qk;
        end else begin
            if (w_hit_j) begin
                r_e.vj <= i_cdb_data;
                r_e.qj <= '0;
            end
            if (w_hit_k) begin
                r_e.vk <= i_cdb_data;
                r_e.qk <= '0;
            end
            if (i_dispatch)
                r_e.disp <= 1'b1;
            if (i_free) begin
                r_e.busy <= 1'b0;
                r_e.disp <= 1'b0;
            end
        end
    end

    assign o_busy  = r_e.busy;
    assign o_ready = r_e.busy && !r_e.disp && (r_e.qj == '0) && (r_e.qk == '0);
    assign o_op    = r_e.op;
    assign o_vj    = r_e.vj;
    assign o_vk    = r_e.vk;
endmodule

module reservation_station #(
    parameter int DATA_W   = 9,
    parameter int ENTRIES  = 3,
    parameter int TAG_W    = 3,
    parameter int TAG_BASE = 1,
    parameter int LATENCY  = 2,
    parameter int MODE     = 0,
    localparam int OCC_W   = $clog2(ENTRIES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    output logic               issue_ready,
    output logic [TAG_W-1:0]   issue_tag,
    input  logic               issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic [TAG_W-1:0]   issue_qj,
    input  logic [TAG_W-1:0]   issue_qk,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               res_valid,
    output logic [TAG_W-1:0]   res_tag,
    output logic [DATA_W-1:0]  res_data,
    input  logic               res_grant,
    output logic [ENTRIES-1:0] busy,
    output logic [OCC_W-1:0]   occupancy
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                          r_state, w_next;
    logic [ENTRIES-1:0]              w_busy, w_ready, w_op;
    logic [ENTRIES-1:0][DATA_W-1:0]  w_vj, w_vk;
    logic                            w_any_free, w_any_rdy, w_dispatch, w_release;
    logic [IDX_W-1:0]                w_free_idx, w_rdy_idx;
    logic [OCC_W-1:0]                w_occ;
    logic                            w_fwd_j, w_fwd_k;
    logic [DATA_W-1:0]               w_ivj, w_ivk, w_result;
    logic [TAG_W-1:0]                w_iqj, w_iqk;
    logic [DATA_W-1:0]               r_a, r_b, r_res_data;
    logic [TAG_W-1:0]                r_res_tag;
    logic                            r_op;
    logic [IDX_W-1:0]                r_idx;
    logic [CNT_W-1:0]                r_cnt;

    // A producer broadcasting on the issue edge must not be missed.
    assign w_fwd_j = cdb_valid && (cdb_tag != '0) && (issue_qj == cdb_tag);
    assign w_fwd_k = cdb_valid && (cdb_tag != '0) && (issue_qk == cdb_tag);
    assign w_ivj   = w_fwd_j ? cdb_data : issue_vj;
    assign w_ivk   = w_fwd_k ? cdb_data : issue_vk;
    assign w_iqj   = w_fwd_j ? '0 : issue_qj;
    assign w_iqk   = w_fwd_k ? '0 : issue_qk;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
            .clock      (clock),
            .reset      (reset),
            .i_alloc    (issue_valid && w_any_free && (w_free_idx == IDX_W'(g))),
            .i_op       (issue_op),
            .i_vj       (w_ivj),
            .i_vk       (w_ivk),
            .i_qj       (w_iqj),
            .i_qk       (w_iqk),
            .i_cdb_valid(cdb_valid),
            .i_cdb_tag  (cdb_tag),
            .i_cdb_data (cdb_data),
            .i_dispatch (w_dispatch && (w_rdy_idx == IDX_W'(g))),
            .i_free     (w_release && (r_idx == IDX_W'(g))),
            .o_busy     (w_busy[g]),
            .o_ready    (w_ready[g]),
            .o_op       (w_op[g]),
            .o_vj       (w_vj[g]),
            .o_vk       (w_vk[g])
        );
    end

    // Descending scan so the lowest index wins.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_any_rdy  = 1'b0;
        w_rdy_idx  = '0;
        w_occ      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_any_rdy = 1'b1;
                w_rdy_idx = IDX_W'(i);
            end
            w_occ = w_occ + OCC_W'(w_busy[i]);
        end
    end

    always_comb begin
        if (MODE == 1)
            w_result = r_a * r_b;
        else if (r_op)
            w_result = r_a - r_b;
        else
            w_result = r_a + r_b;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_dispatch = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            S_IDLE: if (w_any_rdy) begin
                w_dispatch = 1'b1;
                w_next     = S_EXEC;
            end
            S_EXEC: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: if (res_grant) begin
                w_release = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_res_tag  <= '0;
            r_res_data <= '0;
        end else if (w_dispatch) begin
            r_a   <= w_vj[w_rdy_idx];
            r_b   <= w_vk[w_rdy_idx];
            r_op  <= w_op[w_rdy_idx];
            r_idx <= w_rdy_idx;
            r_cnt <= CNT_W'(LATENCY - 1);
        end else if (r_state == S_EXEC) begin
            if (r_cnt == '0) begin
                r_res_data <= w_result;
                r_res_tag  <= TAG_W'(TAG_BASE) + TAG_W'(r_idx);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign issue_ready = w_any_free;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
    assign busy        = w_busy;
    assign occupancy   = w_occ;
    assign res_valid   = (r_state == S_DONE);
    assign res_tag     = r_res_tag;
    assign res_data    = r_res_data;
endmodule
